apb_bridge_arbiter: RTL and testbench
=====================================

APB_BRIDGE_ARBITER -- requirements
Module: apb_bridge_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: address and data width on all ports.
REQ-002 The block SHALL have parameter NUM_MASTERS, default 2: number of requesters; only 2 is supported.
REQ-003 The block SHALL have port hclk_i, input, 1: clock; all state changes on the rising edge.
REQ-004 The block SHALL have port hreset_i, input, 1: reset, asynchronous, active-low.
REQ-005 The block SHALL have port m_req_i, input, NUM_MASTERS: per-master transfer request; held high by the master until its m_ready_o pulse.
REQ-006 The block SHALL have port m_addr_i, input, NUM_MASTERS*DATA_WIDTH: per-master address, master n at bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-007 The block SHALL have port m_write_i, input, NUM_MASTERS: per-master direction; 1 = write.
REQ-008 The block SHALL have port m_wdata_i, input, NUM_MASTERS*DATA_WIDTH: per-master write data, packed as m_addr_i.
REQ-009 The block SHALL have port m_rdata_o, output, DATA_WIDTH: read data, shared by all masters; valid only with m_ready_o.
REQ-010 The block SHALL have port m_ready_o, output, NUM_MASTERS: one-cycle completion pulse to the granted master.
REQ-011 The block SHALL have port m_resp_o, output, NUM_MASTERS: error flag, valid with m_ready_o.
REQ-012 The block SHALL have port hsel_o, output, 1: bridge select, driven high for exactly one cycle per transfer.
REQ-013 The block SHALL have ports haddr_o, hwrite_o and hwdata_o, output, DATA_WIDTH/1/DATA_WIDTH: bridge address, direction and write data.
REQ-014 The block SHALL have ports hrdata_i, hready_i and hresp_i, input, DATA_WIDTH/1/1: bridge read data, ready and error.
REQ-015 The block SHALL have port grant_o, output, NUM_MASTERS: one-hot current owner; all zero when idle.
REQ-016 The block SHALL have port err_sticky_o, output, NUM_MASTERS: per-master sticky error flag.
REQ-017 The block SHALL have port err_clr_i, input, NUM_MASTERS: per-master clear for err_sticky_o.

Function
REQ-018 The block SHALL implement FSM states ARB, ADDR, WAIT and TURN.
REQ-019 In ARB with any m_req_i set, the block SHALL grant one master by round-robin, latch its address, write flag and write data into registers, and go to ADDR.
REQ-020 Round-robin SHALL give priority to the master not served last; after reset master 0 has priority.
REQ-021 In ADDR, hsel_o SHALL be 1 for one cycle and the FSM SHALL then go to WAIT.
REQ-022 haddr_o, hwrite_o and hwdata_o SHALL come from the latched registers and stay constant from ADDR through WAIT, independent of later master input changes.
REQ-023 In WAIT, hsel_o SHALL be 0.
REQ-024 In WAIT, when hready_i=1 the block SHALL pulse the granted master's m_ready_o for that same cycle (combinational), drive m_resp_o from hresp_i, drive m_rdata_o from hrdata_i, and go to TURN.
REQ-025 m_rdata_o SHALL be 0 for writes and outside the hready_i cycle.
REQ-026 TURN SHALL last one cycle with hsel_o=0 so the bridge returns to its idle state, then the FSM SHALL go to ARB; minimum transfer length is therefore 4 cycles.
REQ-027 If hready_i=1 in ADDR or TURN, the block SHALL ignore it.
REQ-028 When hresp_i=1 with hready_i=1, the block SHALL set err_sticky_o[granted]; if err_clr_i is set in the same cycle, set SHALL win.
REQ-029 grant_o SHALL be one-hot during ADDR, WAIT and TURN, and all zero in ARB.
REQ-030 A request dropped before being granted SHALL be ignored.
REQ-031 A request dropped after being granted SHALL NOT abort the transfer; it completes normally.
REQ-032 If both masters request in ARB, the block SHALL grant exactly one; the other waits with no m_ready_o.

Reset
REQ-033 While hreset_i=0, the FSM SHALL be in ARB, round-robin priority SHALL be master 0, and all outputs and latched registers SHALL be 0.
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer with no m_ready_o pulse; the bridge is reset by the same hreset_i.

Structure
REQ-035 The FSM state enum and the ARB/ADDR/WAIT/TURN encodings SHALL be defined in package apb_bridge_pkg.
REQ-036 The round-robin grant logic SHALL be sub-module rr_arbiter (inputs req, last_grant; output one-hot grant).

Verification
REQ-037 Master 0 writes 0xDEADBEEF to 0x03000104, bridge hready_i 2 cycles after hsel_o -> hsel_o high exactly 1 cycle, haddr_o=0x03000104 stable throughout, one m_ready_o[0] pulse.
REQ-038 Both masters request reads in the same cycle, 3 consecutive rounds each -> grants alternate 0,1,0,1,0,1.
REQ-039 Master 1 reads with hrdata_i=0x12345678 -> m_rdata_o=0x12345678 only in the m_ready_o[1] cycle, 0 otherwise.
REQ-040 Bridge returns hresp_i=1 to master 0 -> m_resp_o[0]=1 with ready; err_sticky_o[0] set; err_clr_i[0] in the same cycle leaves it set; err_clr_i[0] next cycle clears it.
REQ-041 Master 0 changes m_addr_i during WAIT -> haddr_o unchanged.
REQ-042 hreset_i=0 during WAIT -> all outputs 0 and no ready pulse; after release, master 0 has priority.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared types for the two-master APB bridge arbiter: FSM state encoding and
// parameter defaults used by the arbiter top and its round-robin sub-block.
package apb_bridge_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_TURN = 2'd3
  } state_e;

endpackage : apb_bridge_pkg

// File: rtl/rr_arbiter.sv
// Round-robin grant: the search starts at the master after the one served
// last; an all-zero last_grant (post-reset) starts the search at master 0.
module rr_arbiter
  import apb_bridge_pkg::*;
#(
  parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] last_grant,
  output logic [NUM_MASTERS-1:0] grant
);

  int   start_idx;
  logic found;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    grant     = '0;
    found     = 1'b0;
    start_idx = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (last_grant[i]) start_idx = (i + 1) % NUM_MASTERS;
    end
    for (int k = 0; k < NUM_MASTERS; k++) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!found && (i == (start_idx + k) % NUM_MASTERS) && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/apb_bridge_arbiter.sv
// Arbitrates NUM_MASTERS requesters onto one APB-style bridge port; a granted
// transfer runs ARB -> ADDR -> WAIT (until hready_i) -> TURN -> ARB.
module apb_bridge_arbiter
  import apb_bridge_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS
) (
  input  logic                              hclk_i,
  input  logic                              hreset_i,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]            m_write_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  output logic [DATA_WIDTH-1:0]             m_rdata_o,
  output logic [NUM_MASTERS-1:0]            m_ready_o,
  output logic [NUM_MASTERS-1:0]            m_resp_o,
  output logic                              hsel_o,
  output logic [DATA_WIDTH-1:0]             haddr_o,
  output logic                              hwrite_o,
  output logic [DATA_WIDTH-1:0]             hwdata_o,
  input  logic [DATA_WIDTH-1:0]             hrdata_i,
  input  logic                              hready_i,
  input  logic                              hresp_i,
  output logic [NUM_MASTERS-1:0]            grant_o,
  output logic [NUM_MASTERS-1:0]            err_sticky_o,
  input  logic [NUM_MASTERS-1:0]            err_clr_i
);

  state_e                  state_q, state_d;
  logic [NUM_MASTERS-1:0]  arb_grant;
  logic [NUM_MASTERS-1:0]  grant_q;
  logic [NUM_MASTERS-1:0]  last_grant_q;
  logic [NUM_MASTERS-1:0]  err_q;
  logic [DATA_WIDTH-1:0]   addr_q, wdata_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   sel_addr, sel_wdata;
  logic                    sel_write;
  logic                    arb_take;
  logic                    xfer_done;

  rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr_arbiter (
    .req        (m_req_i),
    .last_grant (last_grant_q),
    .grant      (arb_grant)
  );

  // Capture mux: picks the winning master's command for latching in ARB.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int n = 0; n < NUM_MASTERS; n++) begin
      if (arb_grant[n]) begin
        sel_addr  = m_addr_i[n*DATA_WIDTH +: DATA_WIDTH];
        sel_wdata = m_wdata_i[n*DATA_WIDTH +: DATA_WIDTH];
        sel_write = m_write_i[n];
      end
    end
  end

  assign arb_take  = (state_q == ST_ARB) && (|m_req_i);
  assign xfer_done = (state_q == ST_WAIT) && hready_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ARB:  if (|m_req_i) state_d = ST_ADDR;
      ST_ADDR: state_d = ST_WAIT;
      ST_WAIT: if (hready_i) state_d = ST_TURN;
      ST_TURN: state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge hclk_i or negedge hreset_i) begin
    if (!hreset_i) begin
      state_q      <= ST_ARB;
      grant_q      <= '0;
      last_grant_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q <= state_d;
      if (arb_take) begin
        grant_q      <= arb_grant;
        last_grant_q <= arb_grant;
        addr_q       <= sel_addr;
        wdata_q      <= sel_wdata;
        write_q      <= sel_write;
      end
      // A same-cycle error sets the flag even when a clear is requested.
      err_q <= (err_q & ~err_clr_i) | m_resp_o;
    end
  end

  assign hsel_o       = (state_q == ST_ADDR);
  assign haddr_o      = addr_q;
  assign hwrite_o     = write_q;
  assign hwdata_o     = wdata_q;
  assign grant_o      = (state_q == ST_ARB) ? '0 : grant_q;
  assign m_ready_o    = xfer_done ? grant_q : '0;
  assign m_resp_o     = (xfer_done && hresp_i) ? grant_q : '0;
  assign m_rdata_o    = (xfer_done && !write_q) ? hrdata_i : '0;
  assign err_sticky_o = err_q;

endmodule : apb_bridge_arbiter

// File: tb/tb_apb_bridge_arbiter.sv
// Directed bench for apb_bridge_arbiter: the bench plays both masters and the
// bridge, stepping each transfer cycle by cycle against hand-derived values.
module tb_apb_bridge_arbiter;

  localparam int DW = 32;
  localparam int NM = 2;

  logic             hclk_i = 1'b0;
  logic             hreset_i;
  logic [NM-1:0]    m_req_i;
  logic [NM*DW-1:0] m_addr_i;
  logic [NM-1:0]    m_write_i;
  logic [NM*DW-1:0] m_wdata_i;
  logic [DW-1:0]    m_rdata_o;
  logic [NM-1:0]    m_ready_o;
  logic [NM-1:0]    m_resp_o;
  logic             hsel_o;
  logic [DW-1:0]    haddr_o;
  logic             hwrite_o;
  logic [DW-1:0]    hwdata_o;
  logic [DW-1:0]    hrdata_i;
  logic             hready_i;
  logic             hresp_i;
  logic [NM-1:0]    grant_o;
  logic [NM-1:0]    err_sticky_o;
  logic [NM-1:0]    err_clr_i;

  int            n_compared   = 0;
  int            n_mismatched = 0;
  logic [NM-1:0] exp_err      = '0;

  apb_bridge_arbiter #(.DATA_WIDTH(DW), .NUM_MASTERS(NM)) dut (
    .hclk_i       (hclk_i),
    .hreset_i     (hreset_i),
    .m_req_i      (m_req_i),
    .m_addr_i     (m_addr_i),
    .m_write_i    (m_write_i),
    .m_wdata_i    (m_wdata_i),
    .m_rdata_o    (m_rdata_o),
    .m_ready_o    (m_ready_o),
    .m_resp_o     (m_resp_o),
    .hsel_o       (hsel_o),
    .haddr_o      (haddr_o),
    .hwrite_o     (hwrite_o),
    .hwdata_o     (hwdata_o),
    .hrdata_i     (hrdata_i),
    .hready_i     (hready_i),
    .hresp_i      (hresp_i),
    .grant_o      (grant_o),
    .err_sticky_o (err_sticky_o),
    .err_clr_i    (err_clr_i)
  );

  always #5 hclk_i = ~hclk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk_i);
    #1;
  endtask

  task automatic set_master(input int m, input logic wr, input logic [DW-1:0] addr,
                            input logic [DW-1:0] wdata);
    m_write_i[m]           = wr;
    m_addr_i[m*DW +: DW]   = addr;
    m_wdata_i[m*DW +: DW]  = wdata;
  endtask

  // Entered in an ARB cycle with the request(s) already visible; leaves the
  // DUT in the following ARB cycle. noisy adds stray hready_i in ADDR/TURN,
  // drops the request after grant, scrambles the master's command in WAIT
  // and pulses the other master's request while the bus is busy.
  task automatic xfer(input string tag, input int m, input int wait_n,
                      input logic wr, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [DW-1:0] rd, input logic rsp, input logic noisy,
                      input logic clr_same, input logic clr_next);
    logic [NM-1:0] oh;
    int            other;
    oh    = 2'b01 << m;
    other = 1 - m;
    check({tag, ".arb_grant"}, grant_o, 2'b00);

    tick();
    if (noisy) begin
      hready_i   = 1'b1;
      m_req_i[m] = 1'b0;
    end
    #1;
    check({tag, ".addr_hsel"}, hsel_o, 1'b1);
    check({tag, ".addr_grant"}, grant_o, oh);
    check({tag, ".addr_haddr"}, haddr_o, addr);
    check({tag, ".addr_hwrite"}, hwrite_o, wr);
    check({tag, ".addr_hwdata"}, hwdata_o, wdata);
    check({tag, ".addr_ready"}, m_ready_o, 2'b00);

    for (int w = 0; w < wait_n; w++) begin
      tick();
      hready_i = 1'b0;
      if (noisy) begin
        m_addr_i[m*DW +: DW]  = ~m_addr_i[m*DW +: DW];
        m_wdata_i[m*DW +: DW] = ~m_wdata_i[m*DW +: DW];
        m_req_i[other]        = (w == 0);
      end
      #1;
      check({tag, ".wait_hsel"}, hsel_o, 1'b0);
      check({tag, ".wait_ready"}, m_ready_o, 2'b00);
      check({tag, ".wait_haddr"}, haddr_o, addr);
      check({tag, ".wait_rdata"}, m_rdata_o, '0);
    end

    tick();
    if (noisy) m_req_i[other] = 1'b0;
    hready_i      = 1'b1;
    hrdata_i      = rd;
    hresp_i       = rsp;
    err_clr_i[m]  = clr_same;
    #1;
    check({tag, ".rdy_pulse"}, m_ready_o, oh);
    check({tag, ".rdy_resp"}, m_resp_o, rsp ? oh : 2'b00);
    check({tag, ".rdy_rdata"}, m_rdata_o, wr ? 32'h0 : rd);
    check({tag, ".rdy_hsel"}, hsel_o, 1'b0);
    check({tag, ".rdy_haddr"}, haddr_o, addr);
    check({tag, ".rdy_err_before"}, err_sticky_o, exp_err);
    m_req_i[m] = 1'b0;
    if (rsp) exp_err[m] = 1'b1;
    else if (clr_same) exp_err[m] = 1'b0;

    tick();
    hready_i     = noisy;
    hrdata_i     = 32'hA5A5_A5A5;
    hresp_i      = 1'b0;
    err_clr_i    = '0;
    #1;
    check({tag, ".turn_hsel"}, hsel_o, 1'b0);
    check({tag, ".turn_grant"}, grant_o, oh);
    check({tag, ".turn_ready"}, m_ready_o, 2'b00);
    check({tag, ".turn_rdata"}, m_rdata_o, '0);
    check({tag, ".turn_err"}, err_sticky_o, exp_err);
    err_clr_i[m] = clr_next;
    if (clr_next) exp_err[m] = 1'b0;

    tick();
    hready_i  = 1'b0;
    hrdata_i  = '0;
    err_clr_i = '0;
    #1;
    check({tag, ".end_grant"}, grant_o, 2'b00);
    check({tag, ".end_hsel"}, hsel_o, 1'b0);
    check({tag, ".end_err"}, err_sticky_o, exp_err);
  endtask

  initial begin
    hreset_i  = 1'b0;
    m_req_i   = '0;
    m_addr_i  = '0;
    m_write_i = '0;
    m_wdata_i = '0;
    hrdata_i  = '0;
    hready_i  = 1'b0;
    hresp_i   = 1'b0;
    err_clr_i = '0;
    #1;
    check("rst.grant", grant_o, 2'b00);
    check("rst.hsel", hsel_o, 1'b0);
    check("rst.haddr", haddr_o, 32'h0);
    check("rst.hwdata", hwdata_o, 32'h0);
    check("rst.hwrite", hwrite_o, 1'b0);
    check("rst.ready", m_ready_o, 2'b00);
    check("rst.resp", m_resp_o, 2'b00);
    check("rst.rdata", m_rdata_o, 32'h0);
    check("rst.err", err_sticky_o, 2'b00);
    @(posedge hclk_i);
    @(posedge hclk_i);
    #3 hreset_i = 1'b1;

    // Master 0 write, bridge ready two cycles after hsel_o.
    tick();
    set_master(0, 1'b1, 32'h0300_0104, 32'hDEAD_BEEF);
    m_req_i[0] = 1'b1;
    #1;
    xfer("wr_m0", 0, 1, 1'b1, 32'h0300_0104, 32'hDEAD_BEEF, 32'hCAFE_0000,
         1'b0, 1'b0, 1'b0, 1'b0);

    // Master 1 read; stray hready_i in ADDR/TURN must not complete anything.
    set_master(1, 1'b0, 32'h0000_2000, 32'h0);
    m_req_i[1] = 1'b1;
    #1;
    xfer("rd_m1", 1, 0, 1'b0, 32'h0000_2000, 32'h0, 32'h1234_5678,
         1'b0, 1'b1, 1'b0, 1'b0);

    // Both masters request reads together: master 1 was served last.
    set_master(0, 1'b0, 32'h0000_0100, 32'h0);
    set_master(1, 1'b0, 32'h0000_0200, 32'h0);
    m_req_i = 2'b11;
    #1;
    for (int r = 0; r < 6; r++) begin
      xfer($sformatf("rr%0d", r), r % 2, r % 3, 1'b0,
           (r % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200, 32'h0,
           32'h0000_1000 + r, 1'b0, 1'b0, 1'b0, 1'b0);
      if (r < 4) m_req_i[r % 2] = 1'b1;
      #1;
    end

    // Master 0 command changes during WAIT; dropped requests are ignored.
    set_master(0, 1'b1, 32'h0000_0A00, 32'h5555_AAAA);
    m_req_i[0] = 1'b1;
    #1;
    xfer("hold_m0", 0, 2, 1'b1, 32'h0000_0A00, 32'h5555_AAAA, 32'h0,
         1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("idle.grant", grant_o, 2'b00);
    check("idle.hsel", hsel_o, 1'b0);

    // Error response: clear in the ready cycle loses, clear next cycle wins.
    set_master(0, 1'b0, 32'h0000_0E00, 32'h0);
    m_req_i[0] = 1'b1;
    #1;
    xfer("err_m0", 0, 0, 1'b0, 32'h0000_0E00, 32'h0, 32'h0BAD_0BAD,
         1'b1, 1'b0, 1'b1, 1'b1);

    // Reset during WAIT of a master 1 transfer.
    set_master(0, 1'b0, 32'h0000_0300, 32'h0);
    set_master(1, 1'b1, 32'h0000_0400, 32'h7777_7777);
    m_req_i = 2'b11;
    tick();
    check("rstw.addr_grant", grant_o, 2'b10);
    tick();
    hready_i = 1'b1;
    hresp_i  = 1'b1;
    hrdata_i = 32'hFFFF_0000;
    #1;
    hreset_i = 1'b0;
    #1;
    check("rstw.ready", m_ready_o, 2'b00);
    check("rstw.resp", m_resp_o, 2'b00);
    check("rstw.rdata", m_rdata_o, 32'h0);
    check("rstw.grant", grant_o, 2'b00);
    check("rstw.hsel", hsel_o, 1'b0);
    check("rstw.haddr", haddr_o, 32'h0);
    check("rstw.hwdata", hwdata_o, 32'h0);
    check("rstw.hwrite", hwrite_o, 1'b0);
    check("rstw.err", err_sticky_o, 2'b00);
    @(posedge hclk_i);
    #3;
    hreset_i = 1'b1;
    hready_i = 1'b0;
    hresp_i  = 1'b0;
    hrdata_i = '0;
    tick();
    check("post_rst.grant", grant_o, 2'b01);
    check("post_rst.hsel", hsel_o, 1'b1);
    check("post_rst.haddr", haddr_o, 32'h0000_0300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_apb_bridge_arbiter
